mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 14 +
 rtl/sat_counter8.sv | 21 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and width defaults for the data-memory load/store unit.
package mem_access_unit_pkg;

    localparam int unsigned AddrWDefault = 8;
    localparam int unsigned DataWDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStore,
        StLoadAddr,
        StLoadData
    } state_e;

endpackage

// File: rtl/sat_counter8.sv
// Enable-driven 8-bit counter that sticks at 255 instead of wrapping.
module sat_counter8 (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] count
);

    logic [7:0] count_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (en && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving a registered data memory.
// MEM_ACCESS_STORE_FWD_EN adds last-store forwarding for loads hitting that address.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        load_cnt,
    output logic [7:0]        store_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              accept, load_acc, store_acc;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign load_acc  = accept && !req_write;
    assign store_acc = accept && req_write;

`ifdef MEM_ACCESS_STORE_FWD_EN
    logic              fwd_valid_q;
    logic [ADDR_W-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else if (store_acc) begin
            fwd_valid_q <= 1'b1;
            fwd_addr_q  <= req_addr;
            fwd_data_q  <= req_wdata;
        end
    end

    assign fwd_hit  = load_acc && fwd_valid_q && (req_addr == fwd_addr_q);
    assign fwd_data = fwd_data_q;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (store_acc) begin
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    mem_write_d = 1'b1;
                    state_d     = StStore;
                end else if (fwd_hit) begin
                    // Forwarded load: answer next cycle, memory untouched.
                    resp_valid_d = 1'b1;
                    resp_rdata_d = fwd_data;
                end else if (load_acc) begin
                    mem_addr_d = req_addr;
                    state_d    = StLoadAddr;
                end
            end
            StStore:    state_d = StIdle;
            StLoadAddr: state_d = StLoadData;
            StLoadData: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = mem_rdata;
                state_d      = StIdle;
            end
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= StIdle;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = mem_write_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    sat_counter8 u_load_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .en     (load_acc),
        .count  (load_cnt)
    );

    sat_counter8 u_store_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .en     (store_acc),
        .count  (store_cnt)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a registered-read memory model.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_STORE_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready, resp_valid, mem_write;
    logic [7:0] resp_rdata, mem_addr, mem_wdata, mem_rdata, load_cnt, store_cnt;

    mem_access_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Data memory: registered read, write on mem_write.
    logic       tb_init = 1'b1;
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [7:0] pre_data = 8'h00;
    logic [7:0] mem [256];
    always @(posedge sysclk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else begin
            if (pre_en) mem[pre_addr] <= pre_data;
            if (mem_write) mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] shadow [256];
    logic       lf_valid = 1'b0;
    logic [7:0] lf_addr = 8'h00;
    int         ld_exp = 0;
    int         st_exp = 0;
    int         stores_issued = 0;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    int   wr_run = 0;
    int   wr_pulses = 0;
    exp_t e;
    always @(negedge sysclk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_spurious", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_cycle", cyc, e.cyc);
                check("resp_rdata", int'(resp_rdata), int'(e.data));
            end
        end
        if (mem_write) begin
            wr_run++;
        end else if (wr_run != 0) begin
            check("mem_write_width", wr_run, 1);
            wr_pulses++;
            wr_run = 0;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge, req_valid left high.
    task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int acc);
        exp_t x;
        int   guard = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && guard < 50) begin
            @(negedge sysclk);
            guard++;
        end
        acc = cyc;
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (wr) begin
            shadow[a] = d;
            lf_valid  = 1'b1;
            lf_addr   = a;
            st_exp    = sat(st_exp + 1);
            stores_issued++;
        end else begin
            x.data = shadow[a];
            x.cyc  = (FwdEn && lf_valid && lf_addr == a) ? acc + 1 : acc + 3;
            exp_q.push_back(x);
            ld_exp = sat(ld_exp + 1);
        end
        @(negedge sysclk);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && req_ready) break;
            @(negedge sysclk);
        end
        check("drain_pending", exp_q.size(), 0);
        @(negedge sysclk);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_req_ready"}, int'(req_ready), 1);
        check({pfx, "_mem_write"}, int'(mem_write), 0);
        check({pfx, "_mem_addr"}, int'(mem_addr), 0);
        check({pfx, "_mem_wdata"}, int'(mem_wdata), 0);
        check({pfx, "_resp_valid"}, int'(resp_valid), 0);
        check({pfx, "_resp_rdata"}, int'(resp_rdata), 0);
        check({pfx, "_load_cnt"}, int'(load_cnt), 0);
        check({pfx, "_store_cnt"}, int'(store_cnt), 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_load_cnt"}, int'(load_cnt), ld_exp);
        check({tag, "_store_cnt"}, int'(store_cnt), st_exp);
    endtask

    initial begin
        int a1, a2, a3;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA5;

        repeat (3) @(negedge sysclk);
        reset   = 1'b0;
        tb_init = 1'b0;
        check_reset_values("por");

        // Store then load the same address.
        send(1'b1, 8'h10, 8'h5A, a1);
        send(1'b0, 8'h10, 8'h00, a1);
        drain();
        check("mem_10", int'(mem[8'h10]), 8'h5A);
        check_counts("st_ld");

        // Back-to-back loads with req_valid held.
        send(1'b0, 8'h01, 8'h00, a1);
        req_addr = 8'h02;
        check("ready_load_addr", int'(req_ready), 0);
        @(negedge sysclk);
        check("ready_load_data", int'(req_ready), 0);
        send(1'b0, 8'h02, 8'h00, a2);
        check("b2b_accept_gap", a2 - a1, 3);
        drain();

        // Top address with preloaded memory.
        pre_en = 1'b1; pre_addr = 8'hFF; pre_data = 8'h7E;
        @(negedge sysclk);
        pre_en = 1'b0;
        shadow[8'hFF] = 8'h7E;
        send(1'b0, 8'hFF, 8'h00, a1);
        drain();
        repeat (3) @(negedge sysclk);
        check("mem_addr_hold_ff", int'(mem_addr), 8'hFF);

        // Store to 0xFF then load it (forwarded when enabled), then 0xFE from memory.
        send(1'b1, 8'hFF, 8'hC3, a1);
        send(1'b0, 8'hFF, 8'h00, a1);
        check("fwd_state_idle", int'(req_ready), int'(FwdEn));
        send(1'b0, 8'hFE, 8'h00, a3);
        drain();
        check_counts("fwd");

        // Reset while in LOAD_ADDR.
        send(1'b0, 8'h20, 8'h00, a1);
        check("in_load_addr", int'(req_ready), 0);
        req_valid = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        lf_valid = 1'b0; ld_exp = 0; st_exp = 0;
        @(negedge sysclk);
        reset = 1'b0;
        check_reset_values("mid_rst");
        repeat (5) @(negedge sysclk);
        send(1'b0, 8'h20, 8'h00, a1);
        drain();
        check_counts("post_rst");

        // Saturation: 300 stores after a clean reset.
        reset = 1'b1;
        lf_valid = 1'b0; ld_exp = 0; st_exp = 0;
        @(negedge sysclk);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 8'(i), 8'($urandom_range(0, 255)), a1);
            if (i == 253) check("store_cnt_254", int'(store_cnt), 254);
        end
        drain();
        check_counts("sat");
        send(1'b0, 8'h10, 8'h00, a1);
        drain();
        check("load_after_sat", int'(load_cnt), 1);
        check("write_pulses", wr_pulses, stores_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
